// File: rtl/id_ex_register_pkg.sv
// Shared MIPS decode encodings used by the ID/EX pipeline register.
// ALU op classes and destination-register selects.
package id_ex_register_pkg;
    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
    localparam logic [2:0] ALU_OP_AND   = 3'b011;
    localparam logic [2:0] ALU_OP_OR    = 3'b100;
    localparam logic [2:0] ALU_OP_SLT   = 3'b101;
    localparam logic [2:0] ALU_OP_LUI   = 3'b110;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;
endpackage

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush/bubble insertion and load-use export.
// Optional ID_EX_PERF_CNT_EN adds stall and bubble event counters.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_pc_plus4,
    input  logic [DATA_W-1:0]     i_rs_data,
    input  logic [DATA_W-1:0]     i_rt_data,
    input  logic [DATA_W-1:0]     i_imm_ext,
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_rt_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [4:0]            i_shamt,
    input  logic [5:0]            i_func_code,
    input  logic [5:0]            i_opcode,
    input  logic [2:0]            i_alu_op,
    input  logic                  i_alu_src,
    input  logic [1:0]            i_reg_dst,
    input  logic                  i_reg_write,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_to_reg,
    input  logic                  i_halt,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_pc_plus4,
    output logic [DATA_W-1:0]     o_rs_data,
    output logic [DATA_W-1:0]     o_rt_data,
    output logic [DATA_W-1:0]     o_imm_ext,
    output logic [REG_ADDR_W-1:0] o_rs_addr,
    output logic [REG_ADDR_W-1:0] o_rt_addr,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [4:0]            o_shamt,
    output logic [5:0]            o_func_code,
    output logic [5:0]            o_opcode,
    output logic [2:0]            o_alu_op,
    output logic                  o_alu_src,
    output logic [1:0]            o_reg_dst,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_halt,
`ifdef ID_EX_PERF_CNT_EN
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_bubble_cnt,
`endif
    output logic                  o_load_use
);
    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     pc_plus4;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm_ext;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [4:0]            shamt;
        logic [5:0]            func_code;
        logic [5:0]            opcode;
        logic [2:0]            alu_op;
        logic                  alu_src;
        logic [1:0]            reg_dst;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  halt;
    } entry_t;

    entry_t d, bubble, q;
    logic   load_bubble;

    // Invalid ID slots are squashed the same way as an explicit flush.
    assign load_bubble = i_flush || (!i_stall && !i_valid);

    always_comb begin
        bubble        = '0;
        bubble.alu_op = ALU_OP_ADD;

        d            = '0;
        d.valid      = 1'b1;
        d.pc_plus4   = i_pc_plus4;
        d.rs_data    = i_rs_data;
        d.rt_data    = i_rt_data;
        d.imm_ext    = i_imm_ext;
        d.rs_addr    = i_rs_addr;
        d.rt_addr    = i_rt_addr;
        d.rd_addr    = i_rd_addr;
        d.shamt      = i_shamt;
        d.func_code  = i_func_code;
        d.opcode     = i_opcode;
        d.alu_op     = i_alu_op;
        d.alu_src    = i_alu_src;
        d.reg_dst    = i_reg_dst;
        d.reg_write  = i_reg_write;
        d.mem_read   = i_mem_read;
        d.mem_write  = i_mem_write;
        d.mem_to_reg = i_mem_to_reg;
        d.halt       = i_halt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            q <= bubble;
        else if (load_bubble)
            q <= bubble;
        else if (!i_stall)
            q <= d;
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_stall_cnt  <= '0;
            o_bubble_cnt <= '0;
        end else begin
            if (i_stall && !i_flush)
                o_stall_cnt <= o_stall_cnt + 1'b1;
            if (load_bubble)
                o_bubble_cnt <= o_bubble_cnt + 1'b1;
        end
    end
`endif

    assign o_valid      = q.valid;
    assign o_pc_plus4   = q.pc_plus4;
    assign o_rs_data    = q.rs_data;
    assign o_rt_data    = q.rt_data;
    assign o_imm_ext    = q.imm_ext;
    assign o_rs_addr    = q.rs_addr;
    assign o_rt_addr    = q.rt_addr;
    assign o_rd_addr    = q.rd_addr;
    assign o_shamt      = q.shamt;
    assign o_func_code  = q.func_code;
    assign o_opcode     = q.opcode;
    assign o_alu_op     = q.alu_op;
    assign o_alu_src    = q.alu_src;
    assign o_reg_dst    = q.reg_dst;
    assign o_reg_write  = q.reg_write;
    assign o_mem_read   = q.mem_read;
    assign o_mem_write  = q.mem_write;
    assign o_mem_to_reg = q.mem_to_reg;
    assign o_halt       = q.halt;
    assign o_load_use   = q.valid & q.mem_read;
endmodule

// File: tb/tb_id_ex_register.sv
// Directed, table-driven check of the ID/EX register: reset, load, stall, flush, bubble.
// Secondary fields are derived from rs_data so every output is exercised per vector.
module tb_id_ex_register;
    import id_ex_register_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid;
    logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
    logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
    logic [5:0]  func_code, opcode;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic [1:0]  reg_dst;
    logic        reg_write, mem_read, mem_write, mem_to_reg, halt;

    logic        q_valid, q_alu_src, q_reg_write, q_mem_read, q_mem_write, q_mem_to_reg, q_halt, q_load_use;
    logic [31:0] q_pc_plus4, q_rs_data, q_rt_data, q_imm_ext;
    logic [4:0]  q_rs_addr, q_rt_addr, q_rd_addr, q_shamt;
    logic [5:0]  q_func_code, q_opcode;
    logic [2:0]  q_alu_op;
    logic [1:0]  q_reg_dst;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] q_stall_cnt, q_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_register dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_pc_plus4(pc_plus4), .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm_ext(imm_ext),
        .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .i_rd_addr(rd_addr), .i_shamt(shamt),
        .i_func_code(func_code), .i_opcode(opcode), .i_alu_op(alu_op), .i_alu_src(alu_src),
        .i_reg_dst(reg_dst), .i_reg_write(reg_write), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_mem_to_reg(mem_to_reg), .i_halt(halt),
        .o_valid(q_valid), .o_pc_plus4(q_pc_plus4), .o_rs_data(q_rs_data), .o_rt_data(q_rt_data),
        .o_imm_ext(q_imm_ext), .o_rs_addr(q_rs_addr), .o_rt_addr(q_rt_addr), .o_rd_addr(q_rd_addr),
        .o_shamt(q_shamt), .o_func_code(q_func_code), .o_opcode(q_opcode), .o_alu_op(q_alu_op),
        .o_alu_src(q_alu_src), .o_reg_dst(q_reg_dst), .o_reg_write(q_reg_write),
        .o_mem_read(q_mem_read), .o_mem_write(q_mem_write), .o_mem_to_reg(q_mem_to_reg),
        .o_halt(q_halt),
`ifdef ID_EX_PERF_CNT_EN
        .o_stall_cnt(q_stall_cnt), .o_bubble_cnt(q_bubble_cnt),
`endif
        .o_load_use(q_load_use)
    );

    typedef struct {
        logic        rst_n, stall, flush, valid;
        logic [31:0] rs, rt;
        logic [5:0]  func;
        logic [2:0]  aop;
        logic        mr, mw, rw;
        logic        e_valid;
        logic [31:0] e_rs, e_rt;
        logic [5:0]  e_func;
        logic [2:0]  e_aop;
        logic        e_mr, e_mw, e_rw, e_lu;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic f, input logic v,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] fn,
                         input logic [2:0] aop, input logic mr, input logic mw, input logic rw);
        rst_n = r; stall = s; flush = f; valid = v;
        rs_data = rs; rt_data = rt; func_code = fn; alu_op = aop;
        mem_read = mr; mem_write = mw; reg_write = rw;
        pc_plus4 = rs + 32'h1000;
        imm_ext = ~rs;
        rs_addr = rs[4:0];
        rt_addr = rs[9:5];
        rd_addr = rs[14:10];
        shamt = rs[19:15];
        opcode = rs[25:20];
        reg_dst = rs[1:0];
        alu_src = rs[2];
        mem_to_reg = rs[3];
        halt = rs[4];
    endtask

    // Fields not in the table follow from rs_data for a valid entry, 0 for a bubble.
    task automatic check_derived(input string tag, input logic ev, input logic [31:0] ers);
        check({tag, ".pc_plus4"}, q_pc_plus4, ev ? ers + 32'h1000 : 32'h0);
        check({tag, ".imm_ext"}, q_imm_ext, ev ? ~ers : 32'h0);
        check({tag, ".addrs"}, {17'h0, q_rs_addr, q_rt_addr, q_rd_addr},
              ev ? {17'h0, ers[4:0], ers[9:5], ers[14:10]} : 32'h0);
        check({tag, ".shamt_op"}, {21'h0, q_shamt, q_opcode}, ev ? {21'h0, ers[19:15], ers[25:20]} : 32'h0);
        check({tag, ".misc"}, {27'h0, q_reg_dst, q_alu_src, q_mem_to_reg, q_halt},
              ev ? {27'h0, ers[1:0], ers[2], ers[3], ers[4]} : 32'h0);
    endtask

    function automatic vec_t mk(logic r, logic s, logic f, logic v, logic [31:0] rs, logic [31:0] rt,
                                logic [5:0] fn, logic [2:0] aop, logic mr, logic mw, logic rw,
                                logic ev, logic [31:0] ers, logic [31:0] ert, logic [5:0] efn,
                                logic [2:0] eaop, logic emr, logic emw, logic erw, logic elu);
        vec_t t;
        t.rst_n = r; t.stall = s; t.flush = f; t.valid = v; t.rs = rs; t.rt = rt;
        t.func = fn; t.aop = aop; t.mr = mr; t.mw = mw; t.rw = rw;
        t.e_valid = ev; t.e_rs = ers; t.e_rt = ert; t.e_func = efn; t.e_aop = eaop;
        t.e_mr = emr; t.e_mw = emw; t.e_rw = erw; t.e_lu = elu;
        return t;
    endfunction

    initial begin
        //           rst stl fl  vld rs            rt            fn     aop           mr mw rw   ev rs        rt        fn     aop           mr mw rw lu
        vecs[0]  = mk(0, 0, 0, 1, 32'h11,       32'h22,       6'h20, ALU_OP_RTYPE, 1, 1, 1,  0, 32'h0,    32'h0,    6'h00, ALU_OP_ADD,   0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 32'h11,       32'h22,       6'h20, ALU_OP_RTYPE, 1, 1, 1,  0, 32'h0,    32'h0,    6'h00, ALU_OP_ADD,   0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 1, 32'h5,        32'h7,        6'h20, ALU_OP_RTYPE, 0, 0, 1,  1, 32'h5,    32'h7,    6'h20, ALU_OP_RTYPE, 0, 0, 1, 0);
        vecs[3]  = mk(1, 0, 0, 1, 32'h0001_0100, 32'h200,     6'h00, ALU_OP_ADD,   1, 0, 1,  1, 32'h0001_0100, 32'h200, 6'h00, ALU_OP_ADD, 1, 0, 1, 1);
        vecs[4]  = mk(1, 1, 0, 1, 32'hDEAD_BEEF, 32'h1234,    6'h2A, ALU_OP_SLT,   0, 1, 0,  1, 32'h0001_0100, 32'h200, 6'h00, ALU_OP_ADD, 1, 0, 1, 1);
        vecs[5]  = mk(1, 1, 0, 0, 32'hCAFE_F00D, 32'h5678,    6'h25, ALU_OP_OR,    0, 1, 0,  1, 32'h0001_0100, 32'h200, 6'h00, ALU_OP_ADD, 1, 0, 1, 1);
        vecs[6]  = mk(1, 1, 0, 1, 32'h0BAD_0BAD, 32'h9ABC,    6'h24, ALU_OP_AND,   0, 0, 1,  1, 32'h0001_0100, 32'h200, 6'h00, ALU_OP_ADD, 1, 0, 1, 1);
        vecs[7]  = mk(1, 1, 1, 1, 32'h55,       32'h66,       6'h20, ALU_OP_RTYPE, 1, 1, 1,  0, 32'h0,    32'h0,    6'h00, ALU_OP_ADD,   0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 1, 32'h0FF3_1F3F, 32'h3C,      6'h22, ALU_OP_SUB,   0, 1, 0,  1, 32'h0FF3_1F3F, 32'h3C, 6'h22, ALU_OP_SUB, 0, 1, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 32'h44,       32'h45,       6'h22, ALU_OP_SUB,   1, 1, 1,  0, 32'h0,    32'h0,    6'h00, ALU_OP_ADD,   0, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 1, 32'h66,       32'h77,       6'h00, ALU_OP_ADD,   0, 0, 1,  1, 32'h66,   32'h77,   6'h00, ALU_OP_ADD,   0, 0, 1, 0);
        vecs[11] = mk(0, 1, 0, 1, 32'h88,       32'h89,       6'h20, ALU_OP_RTYPE, 1, 1, 1,  0, 32'h0,    32'h0,    6'h00, ALU_OP_ADD,   0, 0, 0, 0);
        vecs[12] = mk(1, 1, 0, 1, 32'h99,       32'h9A,       6'h21, ALU_OP_RTYPE, 0, 0, 1,  0, 32'h0,    32'h0,    6'h00, ALU_OP_ADD,   0, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 1, 32'h99,       32'h9A,       6'h21, ALU_OP_RTYPE, 0, 0, 1,  1, 32'h99,   32'h9A,   6'h21, ALU_OP_RTYPE, 0, 0, 1, 0);

        apply(0, 0, 0, 0, 32'h0, 32'h0, 6'h0, ALU_OP_ADD, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            apply(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rs, vecs[i].rt,
                  vecs[i].func, vecs[i].aop, vecs[i].mr, vecs[i].mw, vecs[i].rw);
            @(posedge clk);
            #1;
            check({tag, ".valid"}, {31'h0, q_valid}, {31'h0, vecs[i].e_valid});
            check({tag, ".rs_data"}, q_rs_data, vecs[i].e_rs);
            check({tag, ".rt_data"}, q_rt_data, vecs[i].e_rt);
            check({tag, ".func"}, {26'h0, q_func_code}, {26'h0, vecs[i].e_func});
            check({tag, ".alu_op"}, {29'h0, q_alu_op}, {29'h0, vecs[i].e_aop});
            check({tag, ".ctrl"}, {29'h0, q_mem_read, q_mem_write, q_reg_write},
                  {29'h0, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_rw});
            check({tag, ".load_use"}, {31'h0, q_load_use}, {31'h0, vecs[i].e_lu});
            check_derived(tag, vecs[i].e_valid, vecs[i].e_rs);
        end

        // Input changes between edges must not reach the outputs.
        apply(1, 0, 0, 1, 32'hBEEF_0001, 32'h1, 6'h3F, ALU_OP_LUI, 1, 1, 0);
        #2;
        check("nocomb.rs_data", q_rs_data, 32'h99);
        check("nocomb.load_use", {31'h0, q_load_use}, 32'h0);
        @(posedge clk);
        #1;
        check("nocomb.after_edge", q_rs_data, 32'hBEEF_0001);
        check("nocomb.lu_after_edge", {31'h0, q_load_use}, 32'h1);

`ifdef ID_EX_PERF_CNT_EN
        @(negedge clk);
        apply(0, 0, 0, 1, 32'h1, 32'h2, 6'h0, ALU_OP_ADD, 0, 0, 0);
        @(negedge clk);
        check("cnt.reset_stall", q_stall_cnt, 32'h0);
        check("cnt.reset_bubble", q_bubble_cnt, 32'h0);
        apply(1, 0, 0, 1, 32'h1, 32'h2, 6'h0, ALU_OP_ADD, 0, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            stall = 1'b1;
            @(negedge clk);
        end
        stall = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        check("cnt.stall", q_stall_cnt, 32'd4);
        check("cnt.bubble", q_bubble_cnt, 32'd3);
        check("cnt.pipe_valid", {31'h0, q_valid}, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
